// File: rtl/uart_dbg_ctrl_if.sv
// Byte-stream and OBI manager signal bundle for uart_dbg_ctrl.
//   rx_*  : byte stream from the UART receiver (valid/ready)
//   tx_*  : byte stream to the UART transmitter (valid/ready)
//   obi_* : single OBI manager port (req/gnt address phase, rvalid response phase)
// Signal names keep the original port names so existing hookups map one to one.
// modport slave  : the sequencer's view
// modport master : the environment's view (UART + crossbar)
interface uart_dbg_ctrl_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        output rx_ready_o, tx_data_o, tx_valid_o,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  rx_ready_o, tx_data_o, tx_valid_o,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o
    );
endinterface

// File: rtl/uart_dbg_ctrl.sv
// Debug command sequencer: parses READ/WRITE/EXEC byte frames from the UART,
// performs 32-bit word accesses on one OBI manager port and answers with
// ACK / data / EOT bytes. A rising edge on eoc_i is reported as one EOC byte
// between frames.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : rx/tx byte streams and OBI manager port (uart_dbg_ctrl_if.slave)
//   exec_addr_o   : boot address latched by an EXEC frame
//   exec_valid_o  : one-cycle start pulse for the core
//   eoc_i         : end-of-code level from SoC control
//   busy_o        : high whenever a frame or notification is in progress
module uart_dbg_ctrl #(
    parameter logic [7:0] CmdRead  = 8'h11,
    parameter logic [7:0] CmdWrite = 8'h12,
    parameter logic [7:0] CmdExec  = 8'h13,
    parameter logic [7:0] RspAck   = 8'h06,
    parameter logic [7:0] RspEot   = 8'h04,
    parameter logic [7:0] RspEoc   = 8'h14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_dbg_ctrl_if.slave        bus,
    output logic [31:0]           exec_addr_o,
    output logic                  exec_valid_o,
    input  logic                  eoc_i,
    output logic                  busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LEN, S_EXEC, S_TX_RACK, S_BUS_REQ, S_BUS_RSP,
        S_TX_DATA, S_WDATA, S_TX_ACK, S_TX_EOT, S_TX_EOC
    } state_t;

    state_t      state;
    logic [7:0]  cmd_q;
    logic [23:0] addr_sh;    // first three address bytes, little-endian
    logic [1:0]  byte_idx;
    logic [8:0]  word_cnt;   // words still to be completed on the bus
    logic [31:0] rdata_q;    // read word, shifted down one byte per TX byte
    logic        eoc_q;
    logic        eoc_pend;
    logic [31:0] rsp_word;
    logic        eoc_rise;

    assign bus.obi_be_o = 4'hF;

    always_comb begin
        rsp_word = bus.obi_err_i ? 32'hBADCAB1E : bus.obi_rdata_i;
        eoc_rise = eoc_i & ~eoc_q;
        busy_o   = (state != S_IDLE);
        // A pending EOC claims the idle cycle, so no command byte is taken then.
        bus.rx_ready_o = (state == S_ADDR) || (state == S_LEN) || (state == S_WDATA) ||
                         ((state == S_IDLE) && !eoc_pend);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            cmd_q           <= '0;
            addr_sh         <= '0;
            byte_idx        <= '0;
            word_cnt        <= '0;
            rdata_q         <= '0;
            eoc_q           <= 1'b0;
            eoc_pend        <= 1'b0;
            bus.tx_data_o   <= '0;
            bus.tx_valid_o  <= 1'b0;
            bus.obi_req_o   <= 1'b0;
            bus.obi_addr_o  <= '0;
            bus.obi_we_o    <= 1'b0;
            bus.obi_wdata_o <= '0;
            exec_addr_o     <= '0;
            exec_valid_o    <= 1'b0;
        end else begin
            exec_valid_o <= 1'b0;
            eoc_q        <= eoc_i;
            case (state)
                S_IDLE: begin
                    if (eoc_pend) begin
                        bus.tx_data_o  <= RspEoc;
                        bus.tx_valid_o <= 1'b1;
                        state          <= S_TX_EOC;
                    end else if (bus.rx_valid_i) begin
                        if (bus.rx_data_i == CmdRead || bus.rx_data_i == CmdWrite ||
                            bus.rx_data_i == CmdExec) begin
                            cmd_q    <= bus.rx_data_i;
                            byte_idx <= '0;
                            state    <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid_i) begin
                        addr_sh  <= {bus.rx_data_i, addr_sh[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.obi_addr_o <= {bus.rx_data_i, addr_sh[23:2], 2'b00};
                            if (cmd_q == CmdExec) begin
                                exec_addr_o  <= {bus.rx_data_i, addr_sh[23:2], 2'b00};
                                exec_valid_o <= 1'b1;
                                state        <= S_EXEC;
                            end else begin
                                state <= S_LEN;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    bus.tx_data_o  <= RspAck;
                    bus.tx_valid_o <= 1'b1;
                    state          <= S_TX_ACK;
                end
                S_LEN: begin
                    if (bus.rx_valid_i) begin
                        word_cnt     <= (bus.rx_data_i == 8'h00) ? 9'd256 : {1'b0, bus.rx_data_i};
                        bus.obi_we_o <= (cmd_q == CmdWrite);
                        byte_idx     <= '0;
                        if (cmd_q == CmdWrite) begin
                            state <= S_WDATA;
                        end else begin
                            bus.tx_data_o  <= RspAck;
                            bus.tx_valid_o <= 1'b1;
                            state          <= S_TX_RACK;
                        end
                    end
                end
                S_TX_RACK: begin
                    if (bus.tx_ready_i) begin
                        bus.tx_valid_o <= 1'b0;
                        bus.obi_req_o  <= 1'b1;
                        state          <= S_BUS_REQ;
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid_i) begin
                        bus.obi_wdata_o <= {bus.rx_data_i, bus.obi_wdata_o[31:8]};
                        byte_idx        <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.obi_req_o <= 1'b1;
                            state         <= S_BUS_REQ;
                        end
                    end
                end
                S_BUS_REQ: begin
                    if (bus.obi_gnt_i) begin
                        bus.obi_req_o <= 1'b0;
                        state         <= S_BUS_RSP;
                    end
                end
                S_BUS_RSP: begin
                    if (bus.obi_rvalid_i) begin
                        bus.obi_addr_o <= bus.obi_addr_o + 32'd4;
                        word_cnt       <= word_cnt - 9'd1;
                        byte_idx       <= '0;
                        if (bus.obi_we_o) begin
                            if (word_cnt == 9'd1) begin
                                bus.tx_data_o  <= RspAck;
                                bus.tx_valid_o <= 1'b1;
                                state          <= S_TX_ACK;
                            end else begin
                                state <= S_WDATA;
                            end
                        end else begin
                            rdata_q        <= rsp_word;
                            bus.tx_data_o  <= rsp_word[7:0];
                            bus.tx_valid_o <= 1'b1;
                            state          <= S_TX_DATA;
                        end
                    end
                end
                S_TX_DATA: begin
                    if (bus.tx_ready_i) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // word_cnt was already decremented on the response
                            if (word_cnt == 9'd0) begin
                                bus.tx_data_o <= RspEot;
                                state         <= S_TX_EOT;
                            end else begin
                                bus.tx_valid_o <= 1'b0;
                                bus.obi_req_o  <= 1'b1;
                                state          <= S_BUS_REQ;
                            end
                        end else begin
                            bus.tx_data_o <= rdata_q[15:8];
                            rdata_q       <= {8'h00, rdata_q[31:8]};
                        end
                    end
                end
                S_TX_ACK: begin
                    if (bus.tx_ready_i) begin
                        if (cmd_q == CmdWrite) begin
                            bus.tx_data_o <= RspEot;
                            state         <= S_TX_EOT;
                        end else begin
                            bus.tx_valid_o <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end
                end
                S_TX_EOT: begin
                    if (bus.tx_ready_i) begin
                        bus.tx_valid_o <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                S_TX_EOC: begin
                    if (bus.tx_ready_i) begin
                        bus.tx_valid_o <= 1'b0;
                        eoc_pend       <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // a new edge overrides the clear from the EOC byte just sent
            if (eoc_rise) eoc_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
module tb_uart_dbg_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] exec_addr;
    logic        exec_valid;
    logic        eoc = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    uart_dbg_ctrl_if bus();

    uart_dbg_ctrl #(
        .CmdRead(8'h11), .CmdWrite(8'h12), .CmdExec(8'h13),
        .RspAck(8'h06), .RspEot(8'h04), .RspEoc(8'h14)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .exec_addr_o(exec_addr), .exec_valid_o(exec_valid),
        .eoc_i(eoc), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  expq[$];
    logic [31:0] ob_addr_q[$];
    logic        ob_we_q[$];
    logic [31:0] ob_wd_q[$];
    logic [31:0] execq[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] wq[$];
    // environment memory behind the OBI port
    logic [31:0] resp_mem[logic [31:0]];
    // observation logs
    logic [7:0]  tx_log[$];
    int          gnt_cnt = 0;
    logic [31:0] last_gnt_addr = '0;
    logic [31:0] last_exec = '0;

    int tx_mode = 0;   // 0: always ready, 1: random, 2: 1-in-3, 3: never
    bit gnt_en  = 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h need %h", name, act, exp);
        end
    endfunction

    function automatic void miss(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h need nothing", name, act);
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:28] == 4'hE) return 32'hBADCAB1E;
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic void obi_push(input logic [31:0] a, input logic we, input logic [31:0] wd);
        ob_addr_q.push_back(a);
        ob_we_q.push_back(we);
        ob_wd_q.push_back(wd);
    endfunction

    // tx_ready driver
    initial begin
        int cnt = 0;
        bus.tx_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            cnt++;
            case (tx_mode)
                0:       bus.tx_ready_i = 1'b1;
                1:       bus.tx_ready_i = 1'($urandom_range(0, 1));
                2:       bus.tx_ready_i = (cnt % 3 == 0);
                default: bus.tx_ready_i = 1'b0;
            endcase
        end
    end

    // OBI subordinate: random grant, one outstanding, 1..3 cycle response,
    // error for the 0xE0000000 region
    initial begin
        bit          outst = 1'b0;
        int          dly = 0;
        logic [31:0] o_addr = '0;
        logic [31:0] o_wd = '0;
        logic        o_we = 1'b0;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        bus.obi_err_i    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.obi_req_o && bus.obi_gnt_i) begin
                outst  = 1'b1;
                o_addr = bus.obi_addr_o;
                o_we   = bus.obi_we_o;
                o_wd   = bus.obi_wdata_o;
                dly    = $urandom_range(0, 2);
            end
            @(posedge clk); #1;
            bus.obi_rvalid_i = 1'b0;
            bus.obi_err_i    = 1'b0;
            if (rst) begin
                outst         = 1'b0;
                bus.obi_gnt_i = 1'b0;
            end else begin
                if (outst) begin
                    if (dly == 0) begin
                        outst            = 1'b0;
                        bus.obi_rvalid_i = 1'b1;
                        bus.obi_err_i    = (o_addr[31:28] == 4'hE);
                        if (bus.obi_err_i) bus.obi_rdata_i = $urandom;
                        else if (o_we) begin
                            resp_mem[o_addr] = o_wd;
                            bus.obi_rdata_i  = $urandom;
                        end else
                            bus.obi_rdata_i = resp_mem.exists(o_addr) ? resp_mem[o_addr] : dflt(o_addr);
                    end else dly--;
                end
                bus.obi_gnt_i = gnt_en && bus.obi_req_o && !outst && !bus.obi_rvalid_i &&
                                ($urandom_range(0, 1) == 1);
            end
        end
    end

    // compare process
    initial begin
        logic        p_rst = 1'b1, p_txv = 1'b0, p_txr = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_exv = 1'b0;
        logic        p_we = 1'b0;
        logic [7:0]  p_txd = '0;
        logic [31:0] p_addr = '0, p_wd = '0;
        logic        ewe;
        logic [31:0] ewd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tx_valid_o) chk("rx_ready_during_tx", bus.rx_ready_o, 0);
                if (bus.tx_valid_o && bus.tx_ready_i) begin
                    tx_log.push_back(bus.tx_data_o);
                    if (expq.size() == 0) miss("tx_unexpected", bus.tx_data_o);
                    else chk("tx_byte", bus.tx_data_o, expq.pop_front());
                end
                if (bus.obi_req_o) chk("obi_be", bus.obi_be_o, 32'hF);
                if (bus.obi_req_o && bus.obi_gnt_i) begin
                    gnt_cnt++;
                    last_gnt_addr = bus.obi_addr_o;
                    if (ob_addr_q.size() == 0) miss("obi_unexpected", bus.obi_addr_o);
                    else begin
                        chk("obi_addr", bus.obi_addr_o, ob_addr_q.pop_front());
                        ewe = ob_we_q.pop_front();
                        ewd = ob_wd_q.pop_front();
                        chk("obi_we", bus.obi_we_o, ewe);
                        if (ewe) chk("obi_wdata", bus.obi_wdata_o, ewd);
                    end
                end
                if (exec_valid) begin
                    last_exec = exec_addr;
                    if (p_exv) miss("exec_pulse_width", exec_addr);
                    if (execq.size() == 0) miss("exec_unexpected", exec_addr);
                    else chk("exec_addr", exec_addr, execq.pop_front());
                end
                if (!p_rst && p_txv && !p_txr) begin
                    chk("tx_hold_valid", bus.tx_valid_o, 1);
                    chk("tx_hold_data", bus.tx_data_o, p_txd);
                end
                if (!p_rst && p_req && !p_gnt) begin
                    chk("obi_hold_req", bus.obi_req_o, 1);
                    chk("obi_hold_addr", bus.obi_addr_o, p_addr);
                    chk("obi_hold_we", bus.obi_we_o, p_we);
                    if (p_we) chk("obi_hold_wdata", bus.obi_wdata_o, p_wd);
                end
            end
            p_rst  = rst;
            p_txv  = bus.tx_valid_o;
            p_txr  = bus.tx_ready_i;
            p_txd  = bus.tx_data_o;
            p_req  = bus.obi_req_o;
            p_gnt  = bus.obi_gnt_i;
            p_addr = bus.obi_addr_o;
            p_we   = bus.obi_we_o;
            p_wd   = bus.obi_wdata_o;
            p_exv  = exec_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        logic acc;
        step($urandom_range(0, 2));
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        forever begin
            @(negedge clk);
            acc = bus.rx_ready_o;
            @(posedge clk); #1;
            if (acc) break;
            if (++n > 2000) begin
                miss("rx_accept_timeout", b);
                break;
            end
        end
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy && expq.size() == 0 && ob_addr_q.size() == 0 && execq.size() == 0) break;
            if (++n > 30000) begin
                miss("frame_timeout", expq.size());
                expq.delete(); ob_addr_q.delete(); ob_we_q.delete(); ob_wd_q.delete(); execq.delete();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Model: expected TX bytes, OBI accesses and EXEC pulses of a whole frame.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] a = {addr[31:2], 2'b00};
        int          n = (len == 8'd0) ? 256 : int'(len);
        logic [31:0] w;
        case (cmd)
            8'h11: begin
                expq.push_back(8'h06);
                for (int i = 0; i < n; i++) begin
                    w = model_read(a);
                    for (int k = 0; k < 4; k++) expq.push_back(w[8*k +: 8]);
                    obi_push(a, 1'b0, '0);
                    a += 32'd4;
                end
                expq.push_back(8'h04);
            end
            8'h12: begin
                for (int i = 0; i < n; i++) begin
                    obi_push(a, 1'b1, wq[i]);
                    if (a[31:28] != 4'hE) ref_mem[a] = wq[i];
                    a += 32'd4;
                end
                expq.push_back(8'h06);
                expq.push_back(8'h04);
            end
            8'h13: begin
                expq.push_back(8'h06);
                execq.push_back(a);
            end
            default: ;
        endcase
        send_byte(cmd);
        if (cmd >= 8'h11 && cmd <= 8'h13) begin
            for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
            if (cmd != 8'h13) begin
                send_byte(len);
                if (cmd == 8'h12)
                    for (int i = 0; i < n; i++)
                        for (int k = 0; k < 4; k++) send_byte(wq[i][8*k +: 8]);
            end
        end
        wait_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g0;
        int          sel;
        logic [7:0]  cmd, len;
        logic [31:0] addr;
        logic [7:0]  exp_rd[10];

        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = '0;
        rst = 1'b1;
        step(3);
        chk("rst_tx_valid", bus.tx_valid_o, 0);
        chk("rst_obi_req", bus.obi_req_o, 0);
        chk("rst_obi_addr", bus.obi_addr_o, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_exec_addr", exec_addr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step(2);

        // directed WRITE
        tx_log.delete();
        wq = '{32'h12345678, 32'hDEADBEEF};
        run_frame(8'h12, 32'h10000000, 8'd2);
        chk("wr_mem0", resp_mem[32'h10000000], 32'h12345678);
        chk("wr_mem1", resp_mem[32'h10000004], 32'hDEADBEEF);
        chk("wr_tx_count", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            chk("wr_tx0", tx_log[0], 8'h06);
            chk("wr_tx1", tx_log[1], 8'h04);
        end

        // directed READ back
        tx_log.delete();
        g0 = gnt_cnt;
        tx_mode = 1;
        run_frame(8'h11, 32'h10000000, 8'd2);
        exp_rd = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04};
        chk("rd_tx_count", tx_log.size(), 10);
        chk("rd_obi_count", gnt_cnt - g0, 2);
        if (tx_log.size() == 10)
            for (int i = 0; i < 10; i++) chk("rd_tx_literal", tx_log[i], exp_rd[i]);

        // EXEC with low address bits set
        tx_log.delete();
        run_frame(8'h13, 32'h10000083, 8'd0);
        chk("exec_addr_literal", last_exec, 32'h10000080);
        chk("exec_tx_count", tx_log.size(), 1);
        chk("exec_busy_after", busy, 0);

        // 256-word READ wrapping through zero
        tx_log.delete();
        g0 = gnt_cnt;
        run_frame(8'h11, 32'hFFFFFFF0, 8'd0);
        chk("wrap_obi_count", gnt_cnt - g0, 256);
        chk("wrap_last_addr", last_gnt_addr, 32'h000003EC);
        chk("wrap_tx_count", tx_log.size(), 1026);

        // EOC rising mid-READ, 1-in-3 tx_ready
        tx_log.delete();
        tx_mode = 2;
        fork
            run_frame(8'h11, 32'h10000000, 8'd4);
            begin
                step(25);
                eoc = 1'b1;
                expq.push_back(8'h14);
            end
        join
        chk("eoc_tx_count", tx_log.size(), 19);
        if (tx_log.size() >= 2) begin
            chk("eoc_last_byte", tx_log[tx_log.size()-1], 8'h14);
            chk("eoc_after_eot", tx_log[tx_log.size()-2], 8'h04);
        end
        eoc = 1'b0;
        step(2);
        tx_log.delete();
        run_frame(8'h55, 32'h0, 8'd0);
        step(3);
        chk("unknown_busy", busy, 0);
        chk("unknown_no_tx", tx_log.size(), 0);

        // EOC pending while a command is waiting: EOC goes first
        tx_mode = 3;
        eoc = 1'b1;
        expq.push_back(8'h14);
        step(3);
        chk("eoc_stall_rx_ready", bus.rx_ready_o, 0);
        fork
            run_frame(8'h11, 32'h10000004, 8'd1);
            begin
                step(12);
                tx_mode = 0;
            end
        join
        eoc = 1'b0;
        step(2);

        // reset during a stalled WRITE bus request
        gnt_en = 1'b0;
        send_byte(8'h12);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h02);
        for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k));
        step(2);
        chk("stall_req_high", bus.obi_req_o, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_req", bus.obi_req_o, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_txv", bus.tx_valid_o, 0);
        gnt_en = 1'b1;
        step(2);
        run_frame(8'h11, 32'h10000000, 8'd2);

        // randomized frames
        tx_mode = 1;
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       addr = 32'h10000000 + 32'($urandom_range(0, 31));
                1:       addr = 32'h10000040 + 32'($urandom_range(0, 31));
                2:       addr = 32'hE0000000 + 32'($urandom_range(0, 31));
                default: addr = $urandom;
            endcase
            len = 8'($urandom_range(1, 6));
            sel = $urandom_range(0, 9);
            if (sel < 4) cmd = 8'h11;
            else if (sel < 7) cmd = 8'h12;
            else if (sel < 9) cmd = 8'h13;
            else begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd >= 8'h11 && cmd <= 8'h13) cmd = 8'h20;
            end
            wq.delete();
            for (int i = 0; i < 6; i++) wq.push_back($urandom);
            run_frame(cmd, addr, len);
        end

        step(5);
        chk("end_txq_empty", expq.size(), 0);
        chk("end_obiq_empty", ob_addr_q.size(), 0);
        chk("end_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
